lcd_score_formatter: RTL and testbench

- Upstream feeder for the two-line 16-character LCD string printer.
- Converts a binary score (16 bit) and level (8 bit) to decimal ASCII with a sequential double-dabble converter.
- Assembles the top and bottom 128-bit line buffers and drives the printer's available/print handshake.
- Sits between the Simon game logic, which produces score and level, and the LCD string printer.

---
 rtl/lcd_score_formatter.sv | 184 ++++++++++++++++++
 tb/tb_lcd_score_formatter.sv | 398 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lcd_score_formatter.sv
// rtl/lcd_score_formatter.sv - score/level to ASCII line formatter for the 2x16 LCD string printer
// Sequential double-dabble (score then level on one datapath), then one print handshake per update.
module lcd_score_formatter #(
   parameter bit PRINT_ON_RESET = 1'b1,
   parameter bit BLANK_ZEROS    = 1'b1
) (
   input  logic         clk,
   input  logic         reset_n,
   input  logic [15:0]  score,
   input  logic [7:0]   level,
   input  logic         update,
   output logic         busy,
   input  logic         available,
   output logic         print,
   output logic [127:0] topline,
   output logic [127:0] bottomline
);

   typedef enum logic [2:0] {
      IDLE,
      CONV_SCORE,
      CONV_LEVEL,
      FORMAT,
      WAIT_AVAIL,
      PRINT
   } state_t;

   localparam logic [127:0] TOP_RESET    = "SCORE:         0";
   localparam logic [127:0] BOTTOM_RESET = "LEVEL:         0";
   localparam logic [47:0]  SCORE_TAG    = "SCORE:";
   localparam logic [47:0]  LEVEL_TAG    = "LEVEL:";

   state_t      state;
   logic        start;
   logic        pending;
   logic [15:0] pend_score;
   logic [7:0]  pend_level;
   logic [7:0]  op_level;
   logic [3:0]  cnt;
   logic [15:0] bin;
   logic [19:0] bcd;
   logic [19:0] score_bcd;

   logic [19:0] bcd_adj;
   logic [35:0] shifted;
   logic [19:0] bcd_next;
   logic [15:0] bin_next;
   logic [15:0] load_score;
   logic [7:0]  load_level;
   logic [4:0]  s_blank;
   logic [2:0]  l_blank;
   logic [39:0] score_chars;
   logic [23:0] level_chars;

   // Double-dabble step: add 3 to every nibble >= 5, then shift binary MSB into the BCD field.
   always_comb begin
      bcd_adj = bcd;
      for (int i = 0; i < 5; i++) begin
         if (bcd[i*4 +: 4] >= 4'd5) begin
            bcd_adj[i*4 +: 4] = bcd[i*4 +: 4] + 4'd3;
         end
      end
   end

   assign shifted  = {bcd_adj, bin} << 1;
   assign bcd_next = shifted[35:16];
   assign bin_next = shifted[15:0];

   // A request arriving during PRINT is newer than anything already pending.
   assign load_score = update ? score : pend_score;
   assign load_level = update ? level : pend_level;

   // Leading-zero blanking walks down from the top digit; the units digit is never blanked.
   always_comb begin
      s_blank     = '0;
      l_blank     = '0;
      score_chars = '0;
      level_chars = '0;
      s_blank[4]  = BLANK_ZEROS && (score_bcd[19:16] == 4'd0);
      for (int i = 3; i >= 1; i--) begin
         s_blank[i] = s_blank[i+1] && (score_bcd[i*4 +: 4] == 4'd0);
      end
      l_blank[2] = BLANK_ZEROS && (bcd[11:8] == 4'd0);
      l_blank[1] = l_blank[2] && (bcd[7:4] == 4'd0);
      for (int i = 0; i < 5; i++) begin
         score_chars[i*8 +: 8] = s_blank[i] ? 8'h20 : {4'h3, score_bcd[i*4 +: 4]};
      end
      for (int i = 0; i < 3; i++) begin
         level_chars[i*8 +: 8] = l_blank[i] ? 8'h20 : {4'h3, bcd[i*4 +: 4]};
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state      <= IDLE;
         busy       <= 1'b0;
         print      <= 1'b0;
         pending    <= 1'b0;
         start      <= PRINT_ON_RESET;
         pend_score <= '0;
         pend_level <= '0;
         op_level   <= '0;
         cnt        <= '0;
         bin        <= '0;
         bcd        <= '0;
         score_bcd  <= '0;
         topline    <= TOP_RESET;
         bottomline <= BOTTOM_RESET;
      end else begin
         print <= 1'b0;
         if (update && (state != IDLE || start)) begin
            pending    <= 1'b1;
            pend_score <= score;
            pend_level <= level;
         end
         case (state)
            IDLE: begin
               if (start) begin
                  start <= 1'b0;
                  state <= WAIT_AVAIL;
                  busy  <= 1'b1;
               end else if (update) begin
                  bin      <= score;
                  op_level <= level;
                  bcd      <= '0;
                  cnt      <= '0;
                  state    <= CONV_SCORE;
                  busy     <= 1'b1;
               end
            end
            CONV_SCORE: begin
               bcd <= bcd_next;
               bin <= bin_next;
               cnt <= cnt + 4'd1;
               if (cnt == 4'd15) begin
                  score_bcd <= bcd_next;
                  bcd       <= '0;
                  bin       <= {op_level, 8'h00};
                  cnt       <= '0;
                  state     <= CONV_LEVEL;
               end
            end
            CONV_LEVEL: begin
               bcd <= bcd_next;
               bin <= bin_next;
               cnt <= cnt + 4'd1;
               if (cnt == 4'd7) begin
                  cnt   <= '0;
                  state <= FORMAT;
               end
            end
            FORMAT: begin
               topline    <= {SCORE_TAG, {5{8'h20}}, score_chars};
               bottomline <= {LEVEL_TAG, {7{8'h20}}, level_chars};
               state      <= WAIT_AVAIL;
            end
            WAIT_AVAIL: begin
               if (available) begin
                  print <= 1'b1;
                  state <= PRINT;
               end
            end
            PRINT: begin
               if (update || pending) begin
                  pending  <= 1'b0;
                  bin      <= load_score;
                  op_level <= load_level;
                  bcd      <= '0;
                  cnt      <= '0;
                  state    <= CONV_SCORE;
               end else begin
                  busy  <= 1'b0;
                  state <= IDLE;
               end
            end
            default: begin
               busy  <= 1'b0;
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_lcd_score_formatter.sv
// tb/tb_lcd_score_formatter.sv - scoreboard bench for lcd_score_formatter
// Two instances in lockstep: defaults, and PRINT_ON_RESET=0 / BLANK_ZEROS=0.
module tb_lcd_score_formatter;

   logic         clk = 1'b0;
   logic         reset_n = 1'b0;
   logic [15:0]  score = '0;
   logic [7:0]   level = '0;
   logic         update = 1'b0;
   logic         available = 1'b1;
   logic         busy, print, busy_nb, print_nb;
   logic [127:0] topline, bottomline, topline_nb, bottomline_nb;

   int vectors = 0;
   int miscompares = 0;
   logic [255:0] q[$];
   logic [255:0] q_nb[$];

   localparam logic [255:0] RESET_LINES = {"SCORE:         0", "LEVEL:         0"};

   always #5 clk = ~clk;

   lcd_score_formatter #(.PRINT_ON_RESET(1'b1), .BLANK_ZEROS(1'b1)) dut (
      .clk(clk), .reset_n(reset_n), .score(score), .level(level), .update(update),
      .busy(busy), .available(available), .print(print),
      .topline(topline), .bottomline(bottomline));

   lcd_score_formatter #(.PRINT_ON_RESET(1'b0), .BLANK_ZEROS(1'b0)) dut_nb (
      .clk(clk), .reset_n(reset_n), .score(score), .level(level), .update(update),
      .busy(busy_nb), .available(available), .print(print_nb),
      .topline(topline_nb), .bottomline(bottomline_nb));

   function automatic logic [39:0] digits(input int v, input int n, input bit blank);
      logic [39:0] r;
      bit lead;
      int p;
      int d;
      r = {5{8'h20}};
      lead = 1'b1;
      p = 1;
      for (int i = 1; i < n; i++) p = p * 10;
      for (int i = n - 1; i >= 0; i--) begin
         d = (v / p) % 10;
         if (blank && lead && d == 0 && i > 0) r[i*8 +: 8] = 8'h20;
         else begin
            lead = 1'b0;
            r[i*8 +: 8] = 8'(8'h30 + d);
         end
         p = p / 10;
      end
      return r;
   endfunction

   function automatic logic [255:0] expect_lines(input int s, input int l, input bit blank);
      logic [39:0] ds;
      logic [39:0] dl;
      ds = digits(s, 5, blank);
      dl = digits(l, 3, blank);
      return {"SCORE:", {5{8'h20}}, ds, "LEVEL:", {7{8'h20}}, dl[23:0]};
   endfunction

   function automatic logic [255:0] pop_dut();
      if (q.size() == 0) return '0;
      return q.pop_front();
   endfunction

   function automatic logic [255:0] pop_nb();
      if (q_nb.size() == 0) return '0;
      return q_nb.pop_front();
   endfunction

   // Caller sits at a negedge; returns at the negedge of cycle 1 after the accepting edge.
   task automatic apply_update(input int s, input int l, input bit push);
      score = 16'(s);
      level = 8'(l);
      update = 1'b1;
      if (push) begin
         q.push_back(expect_lines(s, l, 1'b1));
         q_nb.push_back(expect_lines(s, l, 1'b0));
      end
      @(negedge clk);
      update = 1'b0;
   endtask

   task automatic test_reset();
      int first;
      int nb_events;
      logic [255:0] exp;
      reset_n = 1'b0;
      available = 1'b1;
      update = 1'b0;
      repeat (3) @(negedge clk);
      vectors++;
      if (busy !== 1'b0 || print !== 1'b0 || busy_nb !== 1'b0 || print_nb !== 1'b0) begin
         miscompares++;
         $display("FAIL reset_ctrl got busy=%b print=%b busy_nb=%b print_nb=%b exp all 0", busy, print, busy_nb, print_nb);
      end
      vectors++;
      if ({topline, bottomline} !== RESET_LINES || {topline_nb, bottomline_nb} !== RESET_LINES) begin
         miscompares++;
         $display("FAIL reset_lines got=\"%s\" nb=\"%s\" exp=\"%s\"", {topline, bottomline}, {topline_nb, bottomline_nb}, RESET_LINES);
      end
      reset_n = 1'b1;
      q.push_back(RESET_LINES);
      first = 0;
      nb_events = 0;
      for (int k = 1; k <= 6; k++) begin
         @(negedge clk);
         if (print === 1'b1 && first == 0) begin
            first = k;
            exp = pop_dut();
            vectors++;
            if ({topline, bottomline} !== exp) begin
               miscompares++;
               $display("FAIL reset_print_lines got=\"%s\" exp=\"%s\"", {topline, bottomline}, exp);
            end
         end
         if (print_nb !== 1'b0 || busy_nb !== 1'b0) nb_events++;
      end
      vectors++;
      if (first < 1 || first > 2) begin
         miscompares++;
         $display("FAIL reset_print_time got cycle=%0d exp 1..2", first);
      end
      vectors++;
      if (busy !== 1'b0) begin
         miscompares++;
         $display("FAIL reset_busy_after got=%b exp=0", busy);
      end
      vectors++;
      if (nb_events != 0) begin
         miscompares++;
         $display("FAIL reset_nb_quiet got=%0d busy/print cycles exp=0", nb_events);
      end
      q.delete();
   endtask

   task automatic test_latency();
      int first;
      int cnt;
      int cnt_nb;
      logic busy1;
      logic busy28;
      logic [255:0] exp;
      first = 0; cnt = 0; cnt_nb = 0; busy1 = 1'b0; busy28 = 1'b1;
      available = 1'b1;
      apply_update(12345, 7, 1'b1);
      for (int k = 1; k <= 32; k++) begin
         if (k > 1) @(negedge clk);
         if (k == 1) busy1 = busy;
         if (k == 28) busy28 = busy;
         if (print_nb === 1'b1) begin
            cnt_nb++;
            exp = pop_nb();
            vectors++;
            if ({topline_nb, bottomline_nb} !== exp) begin
               miscompares++;
               $display("FAIL latency_lines_nb got=\"%s\" exp=\"%s\"", {topline_nb, bottomline_nb}, exp);
            end
         end
         if (print === 1'b1) begin
            cnt++;
            if (first == 0) begin
               first = k;
               exp = pop_dut();
               vectors++;
               if ({topline, bottomline} !== exp) begin
                  miscompares++;
                  $display("FAIL latency_lines got=\"%s\" exp=\"%s\"", {topline, bottomline}, exp);
               end
            end
         end
      end
      vectors++;
      if (first != 27) begin
         miscompares++;
         $display("FAIL latency_print_cycle got=%0d exp=27", first);
      end
      vectors++;
      if (cnt != 1 || cnt_nb != 1) begin
         miscompares++;
         $display("FAIL latency_print_width got=%0d nb=%0d exp=1", cnt, cnt_nb);
      end
      vectors++;
      if (busy1 !== 1'b1 || busy28 !== 1'b0) begin
         miscompares++;
         $display("FAIL latency_busy got c1=%b c28=%b exp c1=1 c28=0", busy1, busy28);
      end
   endtask

   task automatic test_values();
      int ts[4];
      int tl[4];
      bit seen;
      logic [255:0] exp;
      logic [255:0] exp_nb;
      ts = '{65535, 100, 0, 9};
      tl = '{255, 10, 0, 99};
      available = 1'b1;
      for (int i = 0; i < 4; i++) begin
         apply_update(ts[i], tl[i], 1'b1);
         seen = 1'b0;
         for (int k = 1; k <= 40 && !seen; k++) begin
            @(negedge clk);
            if (print === 1'b1) seen = 1'b1;
         end
         vectors++;
         if (!seen) begin
            miscompares++;
            $display("FAIL values_timeout[%0d] got no print exp print within 40 cycles", i);
            q.delete();
            q_nb.delete();
         end else begin
            exp = pop_dut();
            exp_nb = pop_nb();
            vectors++;
            if ({topline, bottomline} !== exp) begin
               miscompares++;
               $display("FAIL values_lines[%0d] got=\"%s\" exp=\"%s\"", i, {topline, bottomline}, exp);
            end
            vectors++;
            if ({topline_nb, bottomline_nb} !== exp_nb) begin
               miscompares++;
               $display("FAIL values_lines_nb[%0d] got=\"%s\" exp=\"%s\"", i, {topline_nb, bottomline_nb}, exp_nb);
            end
         end
         repeat (2) @(negedge clk);
      end
   endtask

   task automatic test_wait_avail();
      int prints;
      int busy_low;
      int line_bad;
      logic [255:0] peek;
      logic [255:0] exp;
      prints = 0; busy_low = 0; line_bad = 0;
      available = 1'b0;
      apply_update(4321, 42, 1'b1);
      peek = (q.size() > 0) ? q[0] : '0;
      for (int k = 1; k <= 130; k++) begin
         if (k > 1) @(negedge clk);
         if (print !== 1'b0) prints++;
         if (busy !== 1'b1) busy_low++;
         if (k >= 27 && {topline, bottomline} !== peek) line_bad++;
      end
      vectors++;
      if (prints != 0 || busy_low != 0) begin
         miscompares++;
         $display("FAIL wait_hold got prints=%0d busy_low=%0d exp 0/0", prints, busy_low);
      end
      vectors++;
      if (line_bad != 0) begin
         miscompares++;
         $display("FAIL wait_lines_stable got %0d bad cycles exp=0", line_bad);
      end
      available = 1'b1;
      @(negedge clk);
      vectors++;
      if (print !== 1'b1) begin
         miscompares++;
         $display("FAIL wait_release_print got=%b exp=1", print);
      end
      exp = pop_dut();
      void'(pop_nb());
      vectors++;
      if ({topline, bottomline} !== exp) begin
         miscompares++;
         $display("FAIL wait_release_lines got=\"%s\" exp=\"%s\"", {topline, bottomline}, exp);
      end
      @(negedge clk);
      vectors++;
      if (print !== 1'b0 || busy !== 1'b0) begin
         miscompares++;
         $display("FAIL wait_release_after got print=%b busy=%b exp 0/0", print, busy);
      end
   endtask

   task automatic test_back_to_back();
      int cnt;
      int p1;
      int p2;
      int busy_low;
      logic [255:0] exp;
      cnt = 0; p1 = 0; p2 = 0; busy_low = 0;
      available = 1'b1;
      apply_update(1000, 3, 1'b1);
      for (int k = 1; k <= 70; k++) begin
         if (k > 1) @(negedge clk);
         update = 1'b0;
         if (cnt < 2 && busy !== 1'b1) busy_low++;
         if (print === 1'b1) begin
            cnt++;
            if (cnt == 1) p1 = k;
            if (cnt == 2) p2 = k;
            exp = pop_dut();
            void'(pop_nb());
            vectors++;
            if ({topline, bottomline} !== exp) begin
               miscompares++;
               $display("FAIL b2b_lines[%0d] got=\"%s\" exp=\"%s\"", cnt, {topline, bottomline}, exp);
            end
         end
         if (k == 5) begin
            score = 16'd5; level = 8'd1; update = 1'b1;
         end
         if (k == 8) begin
            score = 16'd9; level = 8'd2; update = 1'b1;
            q.push_back(expect_lines(9, 2, 1'b1));
            q_nb.push_back(expect_lines(9, 2, 1'b0));
         end
      end
      vectors++;
      if (cnt != 2 || p1 != 27 || p2 != 54) begin
         miscompares++;
         $display("FAIL b2b_timing got count=%0d p1=%0d p2=%0d exp 2/27/54", cnt, p1, p2);
      end
      vectors++;
      if (busy_low != 0) begin
         miscompares++;
         $display("FAIL b2b_no_idle got %0d idle cycles exp=0", busy_low);
      end
   endtask

   task automatic test_reset_abort();
      int first;
      int nb_events;
      logic [255:0] exp;
      first = 0; nb_events = 0;
      available = 1'b1;
      apply_update(777, 8, 1'b1);
      for (int k = 2; k <= 10; k++) begin
         @(negedge clk);
         update = 1'b0;
         if (k == 4) begin
            score = 16'd555; level = 8'd5; update = 1'b1;
         end
      end
      reset_n = 1'b0;
      #1;
      vectors++;
      if (busy !== 1'b0 || print !== 1'b0 || busy_nb !== 1'b0 || print_nb !== 1'b0) begin
         miscompares++;
         $display("FAIL abort_ctrl got busy=%b print=%b busy_nb=%b print_nb=%b exp all 0", busy, print, busy_nb, print_nb);
      end
      vectors++;
      if ({topline, bottomline} !== RESET_LINES || {topline_nb, bottomline_nb} !== RESET_LINES) begin
         miscompares++;
         $display("FAIL abort_lines got=\"%s\" nb=\"%s\" exp=\"%s\"", {topline, bottomline}, {topline_nb, bottomline_nb}, RESET_LINES);
      end
      q.delete();
      q_nb.delete();
      @(negedge clk);
      reset_n = 1'b1;
      q.push_back(RESET_LINES);
      for (int k = 1; k <= 60; k++) begin
         @(negedge clk);
         if (print === 1'b1 && first == 0) begin
            first = k;
            exp = pop_dut();
            vectors++;
            if ({topline, bottomline} !== exp) begin
               miscompares++;
               $display("FAIL abort_print_lines got=\"%s\" exp=\"%s\"", {topline, bottomline}, exp);
            end
         end
         if (print_nb !== 1'b0 || busy_nb !== 1'b0) nb_events++;
      end
      vectors++;
      if (first < 1 || first > 2) begin
         miscompares++;
         $display("FAIL abort_restart_print got cycle=%0d exp 1..2", first);
      end
      vectors++;
      if (nb_events != 0) begin
         miscompares++;
         $display("FAIL abort_nb_no_print got %0d busy/print cycles exp=0", nb_events);
      end
   endtask

   initial begin
      #300000;
      $display("FAIL watchdog got timeout exp completion");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_latency();
      test_values();
      test_wait_avail();
      test_back_to_back();
      test_reset_abort();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
